// File: rtl/wb_seq_master.sv
// Wishbone classic-cycle initiator: one single-word access per command word, address stepping by 4.
// Optional per-word ack timeout is enabled by defining WB_SEQ_MASTER_ACK_TIMEOUT_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// WDAT  | write burst: waiting for the next write word on the wdat port
// BUS   | cyc/stb asserted, waiting for ack (or timeout when enabled)
// RHOLD | read word held on rdat until the consumer takes it
// FIN   | one-cycle done pulse, err reports abort status
module wb_seq_master #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdat_valid,
    output logic             wdat_ready,
    input  logic [31:0]      wdat,
    output logic             rdat_valid,
    input  logic             rdat_ready,
    output logic [31:0]      rdat,
    output logic             done,
    output logic             err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDAT  = 3'd1,
        BUS   = 3'd2,
        RHOLD = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             live_q;
    logic             we_q;
    logic             err_q;
    logic             timeout;
    logic             cmd_fire;
    logic             last_word;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic [31:0]      rdat_q;
    logic [LEN_W-1:0] cnt_q;

    // live_q keeps cmd_ready low until the first clock after reset release.
    assign cmd_fire  = (state_q == IDLE) && live_q && cmd_valid;
    assign last_word = (cnt_q == LEN_W'(1));

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rdat      = rdat_q;

`ifdef WB_SEQ_MASTER_ACK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q;

    // Reloaded in every other state, so it always starts fresh on entry to BUS.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            timer_q <= '0;
        end else if (state_q != BUS) begin
            timer_q <= TMR_W'(TIMEOUT - 1);
        end else if (timer_q != '0) begin
            timer_q <= timer_q - TMR_W'(1);
        end
    end

    assign timeout = (state_q == BUS) && !wbm_ack_i && (timer_q == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        wdat_ready = 1'b0;
        rdat_valid = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = 4'h0;
        case (state_q)
            IDLE: begin
                cmd_ready = live_q;
                if (cmd_fire) begin
                    if (cmd_len == '0) begin
                        state_d = FIN;
                    end else if (cmd_we) begin
                        state_d = WDAT;
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            WDAT: begin
                wdat_ready = 1'b1;
                if (wdat_valid) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = we_q;
                wbm_sel_o = 4'hF;
                if (wbm_ack_i) begin
                    if (!we_q) begin
                        state_d = RHOLD;
                    end else if (last_word) begin
                        state_d = FIN;
                    end else begin
                        state_d = WDAT;
                    end
                end else if (timeout) begin
                    state_d = FIN;
                end
            end
            RHOLD: begin
                rdat_valid = 1'b1;
                if (rdat_ready) begin
                    state_d = last_word ? FIN : BUS;
                end
            end
            FIN: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count and address step once per completed word: on write ack, or on read handshake.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            rdat_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        we_q  <= cmd_we;
                        adr_q <= cmd_adr & ~32'h3;
                        cnt_q <= cmd_len;
                        err_q <= 1'b0;
                    end
                end
                WDAT: begin
                    if (wdat_valid) begin
                        dat_q <= wdat;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        if (we_q) begin
                            cnt_q <= cnt_q - LEN_W'(1);
                            adr_q <= adr_q + 32'd4;
                        end else begin
                            rdat_q <= wbm_dat_i;
                        end
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                RHOLD: begin
                    if (rdat_ready) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        adr_q <= adr_q + 32'd4;
                    end
                end
                FIN: begin
                    err_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master: a Wishbone slave model with programmable ack delay,
// a stalling read consumer, and queues of expected bus accesses and read words.
module tb_wb_seq_master;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 64;

    logic             wb_clk_i   = 1'b0;
    logic             wb_rst_i   = 1'b1;
    logic             cmd_valid  = 1'b0;
    logic             cmd_we     = 1'b0;
    logic [31:0]      cmd_adr    = '0;
    logic [LEN_W-1:0] cmd_len    = '0;
    logic             wdat_valid = 1'b0;
    logic [31:0]      wdat       = '0;
    logic             rdat_ready = 1'b0;
    logic             cmd_ready, wdat_ready, rdat_valid, done, err;
    logic [31:0]      rdat;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;

    wb_seq_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .rdat_valid (rdat_valid),
        .rdat_ready (rdat_ready),
        .rdat       (rdat),
        .done       (done),
        .err        (err),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_done   = 0;

    int          ack_delay = 1;
    int          rd_stall  = 0;
    logic        ack_en    = 1'b1;
    int          stb_cnt   = 0;
    logic [31:0] mem [0:15];

    int          stb_len      = 0;
    int          last_stb_len = 0;
    int          cyc_cycles   = 0;
    int          rv_cycles    = 0;
    int          done_cnt     = 0;
    int          rv_cnt       = 0;
    logic        prev_ack     = 1'b0;
    logic [31:0] hold_adr     = '0;
    logic [32:0] hold_wd      = '0;
    bus_t        mon_e;
    logic [31:0] mon_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: ack arrives in the ack_delay-th cycle of each strobe.
    assign wbm_ack_i = ack_en && wbm_cyc_o && wbm_stb_o && (stb_cnt == ack_delay - 1);
    assign wbm_dat_i = wbm_ack_i ? mem[wbm_adr_o[5:2]] : 32'h0;

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
        if (wbm_ack_i && wbm_we_o) mem[wbm_adr_o[5:2]] <= wbm_dat_o;
    end

    // Consumer and monitor, both evaluated mid-cycle.
    always @(negedge wb_clk_i) begin
        if (rdat_valid) begin
            rdat_ready = (rv_cnt >= rd_stall);
            rv_cnt++;
            rv_cycles++;
            chk("stb_during_rdat", wbm_stb_o, 0);
        end else begin
            rdat_ready = 1'b0;
            rv_cnt     = 0;
        end
        if (rdat_valid && rdat_ready) begin
            if (exp_rd.size() == 0) begin
                chk("rdat_unexpected", exp_rd.size(), 1);
            end else begin
                mon_r = exp_rd.pop_front();
                chk("rdat", rdat, mon_r);
            end
        end
        if (wbm_cyc_o) cyc_cycles++;
        if (done) done_cnt++;
        if (prev_ack) chk("cyc_gap", wbm_cyc_o, 0);
        if (wbm_cyc_o && wbm_stb_o) begin
            chk("sel", wbm_sel_o, 4'hF);
            if (stb_len == 0) begin
                hold_adr = wbm_adr_o;
                hold_wd  = {wbm_we_o, wbm_dat_o};
            end else begin
                chk("bus_hold_adr", wbm_adr_o, hold_adr);
                chk("bus_hold_wd", {wbm_we_o, wbm_dat_o}, hold_wd);
            end
            if (wbm_ack_i) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", exp_bus.size(), 1);
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_adr", wbm_adr_o, mon_e.adr);
                    chk("bus_we", wbm_we_o, mon_e.we);
                    if (mon_e.we) chk("bus_dat", wbm_dat_o, mon_e.dat);
                end
            end
            stb_len++;
        end else begin
            if (stb_len != 0) last_stb_len = stb_len;
            stb_len = 0;
            chk("sel_idle", wbm_sel_o, 0);
        end
        prev_ack = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic push_bus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus_t e;
        e.we  = we;
        e.adr = adr;
        e.dat = dat;
        exp_bus.push_back(e);
    endtask

    // Returns one step after the accept edge.
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [LEN_W-1:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_accept_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d, input int gap);
        int n = 0;
        repeat (gap) tick();
        wdat       = d;
        wdat_valid = 1'b1;
        while (!wdat_ready && n < 200) begin
            tick();
            n++;
        end
        chk("wdat_wait", wdat_ready, 1);
        tick();
        wdat_valid = 1'b0;
        chk("wr_stb_latency", wbm_stb_o, 1);
        chk("wr_dat_o", wbm_dat_o, d);
    endtask

    task automatic wait_done(input logic exp_err);
        int n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        if (done) n_done++;
        chk("err_with_done", err, exp_err);
        tick();
        chk("done_one_cycle", done, 0);
        chk("err_cleared", err, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic chk_empty();
        chk("exp_bus_left", exp_bus.size(), 0);
        chk("exp_rd_left", exp_rd.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_a;
        int snap_b;
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[1]  = 32'hDEAD_BEEF;
        mem[3]  = 32'h0000_0044;
        mem[15] = 32'hF00D_000F;

        // Reset state and synchronous release
        repeat (2) tick();
        chk("rst_ctrl", {cmd_ready, wdat_ready, rdat_valid, done, err,
                         wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat", {wbm_dat_o, rdat}, 0);
        wb_rst_i = 1'b0;
        chk("rst_release_ready", cmd_ready, 0);
        tick();
        chk("ready_after_release", cmd_ready, 1);

        // Single read, 11-cycle ack, same-cycle rdat handshake
        ack_delay = 11;
        rd_stall  = 0;
        push_bus(1'b0, 32'h3800_0004, 32'h0);
        exp_rd.push_back(32'hDEAD_BEEF);
        send_cmd(1'b0, 32'h3800_0004, 8'd1);
        chk("rd_stb_latency", wbm_stb_o, 1);
        chk("rd_we_low", wbm_we_o, 0);
        wait_done(1'b0);
        chk("rd_stb_len", last_stb_len, 11);
        chk_empty();

        // Write burst with 2-cycle wdat gaps
        ack_delay = 3;
        push_bus(1'b1, 32'h3800_0000, 32'h11);
        push_bus(1'b1, 32'h3800_0004, 32'h22);
        push_bus(1'b1, 32'h3800_0008, 32'h33);
        send_cmd(1'b1, 32'h3800_0000, 8'd3);
        chk("wr_wdat_state", {wdat_ready, wbm_stb_o}, 2'b10);
        feed(32'h11, 2);
        feed(32'h22, 2);
        feed(32'h33, 2);
        wait_done(1'b0);
        chk_empty();

        // Read burst with consumer stalls; low address bits ignored
        ack_delay = 2;
        rd_stall  = 5;
        push_bus(1'b0, 32'h3800_0000, 32'h0);
        push_bus(1'b0, 32'h3800_0004, 32'h0);
        push_bus(1'b0, 32'h3800_0008, 32'h0);
        push_bus(1'b0, 32'h3800_000C, 32'h0);
        exp_rd.push_back(32'h11);
        exp_rd.push_back(32'h22);
        exp_rd.push_back(32'h33);
        exp_rd.push_back(32'h44);
        send_cmd(1'b0, 32'h3800_0003, 8'd4);
        chk("rdb_stb_latency", wbm_stb_o, 1);
        wait_done(1'b0);
        chk_empty();

        // Address wrap
        ack_delay = 1;
        rd_stall  = 1;
        push_bus(1'b0, 32'hFFFF_FFFC, 32'h0);
        push_bus(1'b0, 32'h0000_0000, 32'h0);
        exp_rd.push_back(32'hF00D_000F);
        exp_rd.push_back(32'h11);
        send_cmd(1'b0, 32'hFFFF_FFFC, 8'd2);
        wait_done(1'b0);
        chk_empty();

        // Zero-length command
        snap_a = cyc_cycles;
        send_cmd(1'b1, 32'h3800_0000, 8'd0);
        chk("len0_done_now", {done, wbm_cyc_o}, 2'b10);
        wait_done(1'b0);
        chk("len0_no_cyc", cyc_cycles, snap_a);

        // Ack never arrives
        ack_en = 1'b0;
`ifdef WB_SEQ_MASTER_ACK_TIMEOUT_EN
        snap_a = rv_cycles;
        send_cmd(1'b0, 32'h3800_0000, 8'd2);
        wait_done(1'b1);
        chk("to_stb_len", last_stb_len, TIMEOUT);
        chk("to_no_rdat", rv_cycles, snap_a);
        ack_en = 1'b1;
        chk_empty();
`else
        snap_a = done_cnt;
        send_cmd(1'b0, 32'h3800_0000, 8'd2);
        repeat (200) tick();
        chk("no_to_stb_high", wbm_stb_o, 1);
        chk("no_to_no_done", done_cnt, snap_a);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        tick();
        ack_en = 1'b1;
        chk("no_to_recovered", cmd_ready, 1);
`endif

        // Reset during word 2 of a write burst
        ack_delay = 20;
        push_bus(1'b1, 32'h3800_0020, 32'hA1);
        send_cmd(1'b1, 32'h3800_0020, 8'd3);
        feed(32'hA1, 0);
        feed(32'hA2, 0);
        repeat (3) tick();
        snap_b   = done_cnt;
        wb_rst_i = 1'b1;
        #1;
        chk("rst_mid_ctrl", {wbm_cyc_o, wbm_stb_o, done, wdat_ready}, 4'b0000);
        chk("rst_mid_adr", wbm_adr_o, 0);
        repeat (2) tick();
        wb_rst_i = 1'b0;
        repeat (2) tick();
        chk("rst_mid_no_done", done_cnt, snap_b);
        chk_empty();
        ack_delay = 4;
        rd_stall  = 0;
        push_bus(1'b0, 32'h3800_0020, 32'h0);
        exp_rd.push_back(32'hA1);
        send_cmd(1'b0, 32'h3800_0020, 8'd1);
        wait_done(1'b0);
        chk_empty();

        repeat (2) tick();
        chk("done_total", done_cnt, n_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
